// File: rtl/pdata_unit_if.sv
// pdata_unit_if: memory and ALU side of the YASAC data unit.
//
// Groups the instruction fetch port, the data memory port and the ALU
// operand/result port so the data unit can be wired to whatever memories
// and ALU a given configuration uses.
//
// Signals:
//   code_addr  [AW]  instruction address (PC)        unit -> memory
//   code_data  [16]  instruction word                memory -> unit
//   dmem_addr  [AW]  data address (MAR)              unit -> memory
//   dmem_wdata [DW]  data write value (internal bus) unit -> memory
//   dmem_we          data write enable               unit -> memory
//   dmem_rdata [DW]  data read value                 memory -> unit
//   alu_a/alu_b[DW]  ALU operands                    unit -> ALU
//   alu_op     [4]   ALU operation code              unit -> ALU
//   alu_st_in  [8]   current status register         unit -> ALU
//   alu_r      [DW]  ALU result                      ALU -> unit
//   alu_st     [8]   ALU status                      ALU -> unit
//
// Modports: master = data unit, slave = memories/ALU.
interface pdata_unit_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic [AW-1:0] code_addr;
    logic [15:0]   code_data;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_we;
    logic [DW-1:0] dmem_rdata;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [3:0]    alu_op;
    logic [7:0]    alu_st_in;
    logic [DW-1:0] alu_r;
    logic [7:0]    alu_st;

    modport master (
        output code_addr, dmem_addr, dmem_wdata, dmem_we,
               alu_a, alu_b, alu_op, alu_st_in,
        input  code_data, dmem_rdata, alu_r, alu_st
    );

    modport slave (
        input  code_addr, dmem_addr, dmem_wdata, dmem_we,
               alu_a, alu_b, alu_op, alu_st_in,
        output code_data, dmem_rdata, alu_r, alu_st
    );
endinterface

// File: rtl/pdata_unit.sv
// pdata_unit: parametrised YASAC data unit.
//
// Holds PC, IR, the register array, MAR, the status register and the stack
// pointer, and drives the internal bus. Memories and the ALU are external and
// reached through the pdata_unit_if port.
//
// Parameters:
//   DW          data/bus/register width (>= 8)
//   AW          PC/MAR/SP width
//   NREG        register count (power of 2, 2..8)
//   RAMEND      SP preset value
//   STACK_LIMIT lowest legal SP value (stack checking only)
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   op               ALU operation, forwarded to alu_op
//   ipc..rsp         control strobes from the control unit
//   opcode           ir[15:11]
//   s                ir[10:8], status-bit selector
//   status           status register (---SVNZC)
//   sp_ovf, sp_unf   sticky stack overflow/underflow flags
//   mem              memory/ALU port (pdata_unit_if.master)
//
// Build option: define STACK_CHECK_EN to enable stack-bounds checking
// (SP saturates at STACK_LIMIT / RAMEND and raises sp_ovf / sp_unf).
// Without it SP wraps freely and both flags are tied low.
module pdata_unit #(
    parameter int DW          = 8,
    parameter int AW          = 8,
    parameter int NREG        = 8,
    parameter int RAMEND      = 2**AW - 1,
    parameter int STACK_LIMIT = 2**AW - 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  op,
    input  logic        ipc,
    input  logic        clpc,
    input  logic        wpc,
    input  logic        rpc,
    input  logic        wir,
    input  logic        wreg,
    input  logic        inm,
    input  logic        wmem,
    input  logic        rmem,
    input  logic        wmar,
    input  logic        wsreg,
    input  logic        clsb,
    input  logic        sesb,
    input  logic        prsp,
    input  logic        incsp,
    input  logic        decsp,
    input  logic        rsp,
    output logic [4:0]  opcode,
    output logic [2:0]  s,
    output logic [7:0]  status,
    output logic        sp_ovf,
    output logic        sp_unf,
    pdata_unit_if.master mem
);

    localparam int            SW       = $clog2(NREG);
    localparam logic [AW-1:0] SP_TOP   = AW'(RAMEND);
    localparam logic [AW-1:0] SP_LIMIT = AW'(STACK_LIMIT);

    logic [AW-1:0] pc;
    logic [AW-1:0] sp;
    logic [AW-1:0] mar;
    logic [15:0]   ir;
    logic [7:0]    sreg;
    logic [DW-1:0] regs [NREG];

    logic [SW-1:0] sa;
    logic [SW-1:0] sb;
    logic [DW-1:0] k;
    logic [DW-1:0] bus;

    // Instruction fields; register selectors keep only as many bits as the
    // register array needs.
    assign sa     = ir[8 +: SW];
    assign sb     = ir[0 +: SW];
    assign k      = DW'(ir[7:0]);
    assign opcode = ir[15:11];
    assign s      = ir[10:8];
    assign status = sreg;

    // Internal bus source selection, highest priority first.
    // NOTE: every path assigns bus, so no latch is inferred.
    always_comb begin
        if (rmem)
            bus = mem.dmem_rdata;
        else if (rsp)
            bus = DW'(sp);
        else if (rpc)
            bus = DW'(pc);
        else
            bus = mem.alu_r;
    end

    assign mem.code_addr  = pc;
    assign mem.dmem_addr  = mar;
    assign mem.dmem_wdata = bus;
    assign mem.dmem_we    = wmem;
    assign mem.alu_a      = regs[sa];
    assign mem.alu_b      = inm ? k : regs[sb];
    assign mem.alu_op     = op;
    assign mem.alu_st_in  = sreg;

    // NOTE: state uses non-blocking assignments so that operands read this
    // cycle (e.g. alu_a during a wreg) see the pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc   <= '0;
            ir   <= '0;
            mar  <= '0;
            sreg <= '0;
            sp   <= SP_TOP;
            // NOTE: the register array is small and architecturally reset to
            // zero, so it is built from flops rather than a RAM macro.
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else begin
            if (clpc)
                pc <= '0;
            else if (ipc)
                pc <= pc + AW'(1);
            else if (wpc)
                pc <= AW'(bus);

            if (wir)
                ir <= mem.code_data;

            if (wreg)
                regs[sa] <= bus;

            if (wmar)
                mar <= AW'(bus);

            if (wsreg)
                sreg <= mem.alu_st;
            else if (clsb)
                sreg[s] <= 1'b0;
            else if (sesb)
                sreg[s] <= 1'b1;

            if (prsp)
                sp <= SP_TOP;
`ifdef STACK_CHECK_EN
            else if (incsp) begin
                if (sp != SP_TOP)
                    sp <= sp + AW'(1);
            end else if (decsp) begin
                if (sp != SP_LIMIT)
                    sp <= sp - AW'(1);
            end
`else
            else if (incsp)
                sp <= sp + AW'(1);
            else if (decsp)
                sp <= sp - AW'(1);
`endif
        end
    end

`ifdef STACK_CHECK_EN
    // Sticky bound flags; cleared only by reset or a stack preset. They
    // follow the same strobe priority as SP itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_ovf <= 1'b0;
            sp_unf <= 1'b0;
        end else if (prsp) begin
            sp_ovf <= 1'b0;
            sp_unf <= 1'b0;
        end else if (incsp) begin
            if (sp == SP_TOP)
                sp_unf <= 1'b1;
        end else if (decsp) begin
            if (sp == SP_LIMIT)
                sp_ovf <= 1'b1;
        end
    end
`else
    assign sp_ovf = 1'b0;
    assign sp_unf = 1'b0;

    // The lower bound only matters when checking is built in.
    logic unused_sp_limit;
    assign unused_sp_limit = ^SP_LIMIT;
`endif

endmodule
